acs_butterfly: RTL and testbench

//  Add-compare-select butterfly of the hard-decision Viterbi decoder, directly downstream of the bmcXXXXXX branch-metric units.
//  - Takes two predecessor path metrics (states 2j, 2j+1) and four 2-bit branch metrics.
//  - Produces the registered new metrics for states j and j+N/2, plus one survivor decision bit per state for the traceback memory.
//  - One instance per butterfly; the trellis wiring sits at top level.

---
 rtl/acs_butterfly.sv | 91 +++++++++
 tb/tb_acs_butterfly.sv | 134 +++++++++++++
 2 files changed

// File: rtl/acs_butterfly.sv
// Add-compare-select butterfly for the hard-decision Viterbi decoder: one trellis step per in_valid cycle.
// Optional metric normalisation enabled by defining ACS_NORM_EN.
module acs_butterfly #(
  parameter int PM_W     = 7,
  parameter int INIT_PM0 = 0,
  parameter int INIT_PM1 = 127
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [PM_W-1:0] pm_a_in,
  input  logic [PM_W-1:0] pm_b_in,
  input  logic [1:0]      bmc_a0,
  input  logic [1:0]      bmc_b0,
  input  logic [1:0]      bmc_a1,
  input  logic [1:0]      bmc_b1,
  input  logic            norm_in,
  output logic            out_valid,
  output logic [PM_W-1:0] pm_0_out,
  output logic [PM_W-1:0] pm_1_out,
  output logic            dec_0,
  output logic            dec_1,
  output logic            msb_flag
);

  localparam logic [PM_W:0]   MAXV  = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W:0]   HALF  = (PM_W+1)'(1) << (PM_W-1);
  localparam logic [PM_W-1:0] INIT0 = INIT_PM0[PM_W-1:0];
  localparam logic [PM_W-1:0] INIT1 = INIT_PM1[PM_W-1:0];

  logic [PM_W:0]   ca0, cb0, ca1, cb1, s0, s1, n0, n1;
  logic            d0, d1;
  logic [PM_W-1:0] pm0_q, pm0_d, pm1_q, pm1_d;
  logic            dec0_q, dec1_q, vld_q;

  function automatic logic [PM_W-1:0] sat(input logic [PM_W:0] v);
    return (v > MAXV) ? MAXV[PM_W-1:0] : v[PM_W-1:0];
  endfunction

  // Sums carry one extra bit so the compare sees the true value before saturation.
  always_comb begin
    ca0 = {1'b0, pm_a_in} + {{(PM_W-1){1'b0}}, bmc_a0};
    cb0 = {1'b0, pm_b_in} + {{(PM_W-1){1'b0}}, bmc_b0};
    ca1 = {1'b0, pm_a_in} + {{(PM_W-1){1'b0}}, bmc_a1};
    cb1 = {1'b0, pm_b_in} + {{(PM_W-1){1'b0}}, bmc_b1};
    d0  = cb0 < ca0;
    d1  = cb1 < ca1;
    s0  = d0 ? cb0 : ca0;
    s1  = d1 ? cb1 : ca1;
`ifdef ACS_NORM_EN
    n0  = norm_in ? s0 - HALF : s0;
    n1  = norm_in ? s1 - HALF : s1;
`else
    n0  = s0;
    n1  = s1;
`endif
    pm0_d = sat(n0);
    pm1_d = sat(n1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      pm0_q  <= INIT0;
      pm1_q  <= INIT1;
      dec0_q <= 1'b0;
      dec1_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        pm0_q  <= pm0_d;
        pm1_q  <= pm1_d;
        dec0_q <= d0;
        dec1_q <= d1;
      end
    end
  end

  assign out_valid = vld_q;
  assign pm_0_out  = pm0_q;
  assign pm_1_out  = pm1_q;
  assign dec_0     = dec0_q;
  assign dec_1     = dec1_q;
`ifdef ACS_NORM_EN
  assign msb_flag  = pm0_q[PM_W-1] & pm1_q[PM_W-1];
`else
  assign msb_flag  = 1'b0 & norm_in & HALF[0];
`endif

endmodule

// File: tb/tb_acs_butterfly.sv
// Bench for acs_butterfly: integer reference model checked every cycle plus hand-computed literal vectors.
module tb_acs_butterfly;
  localparam int PM_W = 7;
  localparam int MAXV = 127;
`ifdef ACS_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, norm_in = 1'b0;
  logic [PM_W-1:0] pm_a_in = '0, pm_b_in = '0;
  logic [1:0] bmc_a0 = '0, bmc_b0 = '0, bmc_a1 = '0, bmc_b1 = '0;
  logic out_valid, dec_0, dec_1, msb_flag;
  logic [PM_W-1:0] pm_0_out, pm_1_out;

  int checks = 0, errors = 0;
  int e_pm0 = 0, e_pm1 = 0, e_d0 = 0, e_d1 = 0, e_vld = 0;
  bit model_live = 0;

  acs_butterfly #(.PM_W(PM_W), .INIT_PM0(0), .INIT_PM1(127)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pm_a_in(pm_a_in), .pm_b_in(pm_b_in), .bmc_a0(bmc_a0), .bmc_b0(bmc_b0),
    .bmc_a1(bmc_a1), .bmc_b1(bmc_b1), .norm_in(norm_in), .out_valid(out_valid),
    .pm_0_out(pm_0_out), .pm_1_out(pm_1_out), .dec_0(dec_0), .dec_1(dec_1),
    .msb_flag(msb_flag));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Survivor selection in plain integers: smaller sum wins, tie goes to path a.
  function automatic void acs(input int a, b, ba, bb, input bit nrm, output int pm, output int d);
    int sa, sb;
    sa = a + ba;
    sb = b + bb;
    d  = (sb < sa) ? 1 : 0;
    pm = d ? sb : sa;
    if (NORM && nrm) pm -= 64;
    if (pm > MAXV) pm = MAXV;
  endfunction

  always @(posedge clk) begin
    int p0, p1, q0, q1;
    model_live = 1;
    if (!rst_n || start) begin
      e_pm0 = 0; e_pm1 = 127; e_d0 = 0; e_d1 = 0; e_vld = 0;
    end else begin
      e_vld = in_valid;
      if (in_valid) begin
        acs(pm_a_in, pm_b_in, bmc_a0, bmc_b0, norm_in, p0, q0);
        acs(pm_a_in, pm_b_in, bmc_a1, bmc_b1, norm_in, p1, q1);
        e_pm0 = p0; e_pm1 = p1; e_d0 = q0; e_d1 = q1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_live) begin
      chk("out_valid", out_valid, e_vld);
      chk("pm_0_out", pm_0_out, e_pm0);
      chk("pm_1_out", pm_1_out, e_pm1);
      chk("dec_0", dec_0, e_d0);
      chk("dec_1", dec_1, e_d1);
      chk("msb_flag", msb_flag, (NORM && e_pm0 >= 64 && e_pm1 >= 64) ? 1 : 0);
    end
  end

  task automatic drive(input bit st, iv, nm, input int a, b, ba0, bb0, ba1, bb1);
    @(negedge clk);
    start = st; in_valid = iv; norm_in = nm;
    pm_a_in = PM_W'(a); pm_b_in = PM_W'(b);
    bmc_a0 = 2'(ba0); bmc_b0 = 2'(bb0); bmc_a1 = 2'(ba1); bmc_b1 = 2'(bb1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    after_edge();
    chk("t1_pm0", pm_0_out, 0); chk("t1_pm1", pm_1_out, 127);
    chk("t1_vld", out_valid, 0); chk("t1_dec", {dec_0, dec_1}, 0);
    @(negedge clk); rst_n = 1'b1;

    drive(0, 1, 0, 3, 4, 2, 0, 0, 2); after_edge();
    chk("t2_pm0", pm_0_out, 4); chk("t2_dec0", dec_0, 1);
    chk("t2_pm1", pm_1_out, 3); chk("t2_dec1", dec_1, 0); chk("t2_vld", out_valid, 1);

    drive(0, 1, 0, 10, 10, 1, 1, 1, 1); after_edge();
    chk("t3_pm0", pm_0_out, 11); chk("t3_pm1", pm_1_out, 11);
    chk("t3_dec", {dec_0, dec_1}, 0);

    drive(0, 1, 0, 126, 126, 2, 2, 2, 2); after_edge();
    chk("t4_pm0", pm_0_out, 127); chk("t4_pm1", pm_1_out, 127);
    chk("t4_msb", msb_flag, NORM ? 1 : 0);

    drive(0, 0, 1, 5, 5, 0, 0, 0, 0); after_edge();
    chk("hold_pm0", pm_0_out, 127); chk("hold_vld", out_valid, 0);

    drive(0, 1, 0, 50, 60, 0, 0, 2, 1); after_edge();
    chk("t5_pre_pm0", pm_0_out, 50); chk("t5_pre_pm1", pm_1_out, 52);
    drive(1, 1, 0, 20, 30, 1, 1, 1, 1); after_edge();
    chk("t5_pm0", pm_0_out, 0); chk("t5_pm1", pm_1_out, 127);
    chk("t5_vld", out_valid, 0);
    drive(0, 1, 0, 20, 30, 1, 1, 1, 1); after_edge();
    chk("t5_res_pm0", pm_0_out, 21); chk("t5_res_vld", out_valid, 1);

    drive(0, 1, 1, 70, 80, 1, 1, 1, 1); after_edge();
    chk("t6_pm0", pm_0_out, NORM ? 7 : 71); chk("t6_pm1", pm_1_out, NORM ? 7 : 71);
    chk("t6_dec", {dec_0, dec_1}, 0); chk("t6_msb", msb_flag, 0);

    drive(0, 1, 0, 90, 100, 0, 0, 0, 0); after_edge();
    chk("t7_msb", msb_flag, NORM ? 1 : 0);

    for (int i = 0; i < 40; i++)
      drive(0, 1'($urandom_range(0, 3) != 0), 0, $urandom_range(0, 127), $urandom_range(0, 127),
            $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
